// File: rtl/scpu_mem_pkg.sv
// Shared definitions for the system memory bus: widths, sequencer states, port ids.
package scpu_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Bus sequencer states; reads take one more strobe phase than writes.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RD_OE = 3'd3,
    ACK   = 3'd4
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker: a lone requester wins, ties go by priority mode.
module mem_arb_pick
  import scpu_mem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // Tie: fixed mode favours the CPU, round-robin favours whoever lost last time.
  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    if (req == 2'b11)
      winner = FIXED_PRIO ? PORT_CPU : ~last_grant;
    else if (req[1])
      winner = PORT_LDR;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter and strobe sequencer for the shared memory bus.
// Strobes, acks and busy are decoded from state only, so no request input
// reaches the memory combinationally.
module mem_bus_arbiter
  import scpu_mem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce,
  output logic              mem_w,
  output logic              mem_r,
  output logic              mem_oe,
  output logic              busy
);

  arb_state_t state_q, state_d;
  logic       grant_id;
  logic       last_grant;
  logic       pick_vld;
  logic       pick_win;
  logic       sel_we;

  mem_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .valid      (pick_vld),
    .winner     (pick_win)
  );

  assign sel_we = pick_win ? m1_we : m0_we;

  // Next-state: one strobe phase per state, ACK always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = sel_we ? WR : RD;
      WR:      state_d = ACK;
      RD:      state_d = RD_OE;
      RD_OE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight without an ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Capture the winner's fields at grant; held stable until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_id   <= PORT_CPU;
      last_grant <= PORT_LDR;
    end else if (state_q == IDLE && pick_vld) begin
      mem_addr   <= pick_win ? m1_addr  : m0_addr;
      mem_wdata  <= pick_win ? m1_wdata : m0_wdata;
      grant_id   <= pick_win;
      last_grant <= pick_win;
    end
  end

  // Read data lands only in the granted port's register, at the end of RD_OE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state_q == RD_OE) begin
      if (grant_id == PORT_LDR) m1_rdata <= mem_rdata;
      else                      m0_rdata <= mem_rdata;
    end
  end

  assign mem_ce = (state_q == WR) || (state_q == RD) || (state_q == RD_OE);
  assign mem_w  = (state_q == WR);
  assign mem_r  = (state_q == RD);
  assign mem_oe = (state_q == RD_OE);
  assign m0_ack = (state_q == ACK) && (grant_id == PORT_CPU);
  assign m1_ack = (state_q == ACK) && (grant_id == PORT_LDR);
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: round-robin instance with a read/write memory model, plus a
// fixed-priority instance (read-only model) for the starvation case.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr, mem_addr;
  logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic        m0_ack, m1_ack, mem_ce, mem_w, mem_r, mem_oe, busy;

  logic        f_m0_req, f_m1_req, f_m0_ack, f_m1_ack;
  logic [15:0] f_mem_addr;
  logic [7:0]  f_m0_rdata, f_m1_rdata, f_mem_wdata, f_mem_rdata;
  logic        f_mem_ce, f_mem_w, f_mem_r, f_mem_oe, f_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.FIXED_PRIO(1'b0), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce(mem_ce), .mem_w(mem_w), .mem_r(mem_r), .mem_oe(mem_oe), .busy(busy)
  );

  mem_bus_arbiter #(.FIXED_PRIO(1'b1), .ADDR_W(16), .DATA_W(8)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(f_m0_req), .m0_we(1'b0), .m0_addr(16'h0020), .m0_wdata(8'h00),
    .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
    .m1_req(f_m1_req), .m1_we(1'b0), .m1_addr(16'h0010), .m1_wdata(8'h00),
    .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
    .mem_ce(f_mem_ce), .mem_w(f_mem_w), .mem_r(f_mem_r), .mem_oe(f_mem_oe), .busy(f_busy)
  );

  // Preloaded contents, indexed by the low address byte.
  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h10:   return 8'h3C;
      8'h20:   return 8'h77;
      8'h30:   return 8'h5A;
      8'h40:   return 8'h99;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0]   wr_mem [256];
  logic [255:0] wr_vld = '0;

  // Memory model: writes on ce+w, data register loads on ce+r.
  always @(posedge clk) begin
    if (mem_ce && mem_w) begin
      wr_mem[mem_addr[7:0]] <= mem_wdata;
      wr_vld[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_ce && mem_r)
      mem_rdata <= wr_vld[mem_addr[7:0]] ? wr_mem[mem_addr[7:0]] : rom(mem_addr[7:0]);
  end

  always @(posedge clk) begin
    if (f_mem_ce && f_mem_r) f_mem_rdata <= rom(f_mem_addr[7:0]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count negedges until the port's ack, bounded by max cycles.
  task automatic wait_ack(input string tag, input logic port, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(port ? m1_ack : m0_ack) && cyc < max);
    chk({tag, "_ack"}, port ? m1_ack : m0_ack, 1);
  endtask

  int cyc;
  int fa0, fa1;
  int ack_port[$];
  int ack_cyc[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0020; m0_wdata = 8'h00;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0040; m1_wdata = 8'h00;
    f_m0_req = 1'b0; f_m1_req = 1'b0;

    // 1. reset with both requesting
    repeat (3) @(negedge clk);
    chk("rst_strobes", {mem_ce, mem_w, mem_r, mem_oe}, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    rst = 1'b1;
    wait_ack("first", 1'b0, 8, cyc);
    chk("first_lat", cyc, 3);
    chk("first_m1_ack", m1_ack, 0);
    chk("first_rdata", m0_rdata, 8'h77);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("first_idle", busy, 0);

    // 2. port 0 write 0x8000 <- 0xA5
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h8000; m0_wdata = 8'hA5;
    @(negedge clk);
    chk("wr_strobes", {mem_ce, mem_w, mem_r, mem_oe}, 4'b1100);
    chk("wr_addr", mem_addr, 16'h8000);
    chk("wr_wdata", mem_wdata, 8'hA5);
    chk("wr_noack", m0_ack, 0);
    @(negedge clk);
    chk("wr_ack", m0_ack, 1);
    chk("wr_ack_strobes", {mem_ce, mem_w}, 0);
    chk("wr_addr_hold", mem_addr, 16'h8000);
    chk("wr_rdata", {m0_rdata, m1_rdata}, {8'h77, 8'h00});
    m0_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", {m0_ack, busy}, 0);

    // 3. port 1 read 0x0010
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0010;
    @(negedge clk);
    chk("rd_ph1", {mem_ce, mem_w, mem_r, mem_oe}, 4'b1010);
    chk("rd_addr", mem_addr, 16'h0010);
    @(negedge clk);
    chk("rd_ph2", {mem_ce, mem_w, mem_r, mem_oe}, 4'b1001);
    @(negedge clk);
    chk("rd_ack", {m0_ack, m1_ack}, 2'b01);
    chk("rd_m1_rdata", m1_rdata, 8'h3C);
    chk("rd_m0_rdata", m0_rdata, 8'h77);
    m1_req = 1'b0;
    @(negedge clk);

    // 4. both reading continuously; round-robin vs fixed priority
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0020;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0010;
    f_m0_req = 1'b1; f_m1_req = 1'b1;
    fa0 = 0; fa1 = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (m0_ack) begin ack_port.push_back(0); ack_cyc.push_back(c); end
      if (m1_ack) begin ack_port.push_back(1); ack_cyc.push_back(c); end
      if (f_m0_ack) fa0++;
      if (f_m1_ack) fa1++;
    end
    m0_req = 1'b0; m1_req = 1'b0; f_m0_req = 1'b0;
    chk("rr_count", ack_port.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_port.size()) begin
        chk($sformatf("rr_port%0d", i), ack_port[i], i % 2);
        chk($sformatf("rr_cyc%0d", i), ack_cyc[i], 3 + 4 * i);
      end
    end
    chk("rr_rdata", {m0_rdata, m1_rdata}, {8'h77, 8'h3C});
    chk("fp_m0_acks", fa0, 4);
    chk("fp_m1_acks", fa1, 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!f_m1_ack && cyc < 8);
    chk("fp_m1_ack", f_m1_ack, 1);
    chk("fp_m1_lat", cyc, 4);
    chk("fp_m1_rdata", f_m1_rdata, 8'h3C);
    f_m1_req = 1'b0;
    @(negedge clk);

    // 5. reset during RD_OE, held request completes after release
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0030;
    @(negedge clk);
    @(negedge clk);
    chk("rr_oe", mem_oe, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_strobes", {mem_ce, mem_r, mem_oe}, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rdata", m1_rdata, 0);
    fa1 = 0;
    repeat (2) begin
      @(negedge clk);
      if (m1_ack) fa1++;
    end
    chk("mid_noack", fa1, 0);
    rst = 1'b1;
    wait_ack("mid_retry", 1'b1, 8, cyc);
    chk("mid_retry_lat", cyc, 3);
    chk("mid_retry_rdata", m1_rdata, 8'h5A);
    m1_req = 1'b0;
    @(negedge clk);

    // 6. port 0 holds req through ack, write then read the same byte
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0001; m0_wdata = 8'h11;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_wr_ack", m0_ack, 1);
    m0_we = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {busy, mem_ce}, 0);
    @(negedge clk);
    chk("b2b_rd", {mem_ce, mem_r}, 2'b11);
    chk("b2b_addr", mem_addr, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_rd_ack", m0_ack, 1);
    chk("b2b_rdata", m0_rdata, 8'h11);
    m0_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Two-requester arbiter and sequencer for the shared system memory bus (RAM below 0x8000, memory-mapped IO from 0x8000).
- Accepts single-byte read/write requests from port 0 (CPU) and port 1 (loader/DMA), and picks a winner.
- Drives the memory strobe sequence:
  - read: ce+r, then ce+oe;
  - write: ce+w.
- Returns read data with a one-cycle acknowledge. Sits between the CPU/loader and the memory block.

## Interface
Parameters:
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties
- ADDR_W, 16, address width
- DATA_W, 8, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- m0_req  in  1  port 0 request; hold with fields stable until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  DATA_W  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read result; valid with m0_ack, held until next port-0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1
- mem_addr  out  ADDR_W  registered address to memory
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory out_data bus
- mem_ce, mem_w, mem_r, mem_oe  out  1  memory strobes
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WR, RD, RD_OE, ACK. All outputs are registered/decoded from state; nothing is combinational from req to memory.

IDLE
- All strobes 0.
- If any req is high, at the clock edge:
  - pick a winner;
  - latch the winner's addr, wdata and we into mem_addr/mem_wdata;
  - record grant_id;
  - go to WR if we=1, else RD.

WR
- mem_ce=1, mem_w=1.
- Next state: ACK.

RD
- mem_ce=1, mem_r=1 (memory captures into its data register).
- Next state: RD_OE.

RD_OE
- mem_ce=1, mem_oe=1.
- At the edge, capture mem_rdata into the granted port's rdata register.
- Next state: ACK.

ACK
- grant_id's ack=1; strobes 0.
- Next state: IDLE unconditionally.

Arbitration
- last_grant register updates on every grant.
- Round-robin (FIXED_PRIO=0): on a tie, the port not in last_grant wins.
- FIXED_PRIO=1: port 0 wins every tie.
- A single requester always wins.

Port data rules
- Only the granted port's rdata changes; the other port's rdata holds.
- A write never changes any rdata.
- A req still high in the cycle after ack is a new request and is sampled normally in IDLE.

## Timing
- Edge 0 = the IDLE edge that samples the request.
  - Write: WR in cycle 1, ack in cycle 2.
  - Read: RD in cycle 1, RD_OE in cycle 2, ack with valid rdata in cycle 3.
- Minimum request-to-request spacing (IDLE included):
  - write: 3 cycles;
  - read: 4 cycles.
- mem_addr/mem_wdata are stable from WR/RD through ACK.
- Reset values (rst=0):
  - state=IDLE;
  - all strobes 0, m0_ack=m1_ack=0, busy=0;
  - mem_addr=0, mem_wdata=0, m0_rdata=m1_rdata=0;
  - last_grant=1 (port 0 wins the first tie).
- Reset mid-operation:
  - outputs go to reset values immediately, asynchronously;
  - the transaction is dropped with no ack;
  - the requester re-requests after release.
- Requests arriving while busy are held by the requester and are not lost; they are arbitrated at the next IDLE.
- Address boundary: 0x7FFF and 0x8000 need no special handling; decode belongs to memory.

## Structure
- Shared package scpu_mem_pkg:
  - ADDR_W/DATA_W defaults;
  - state encoding constants (IDLE, WR, RD, RD_OE, ACK);
  - port id constants PORT_CPU=0, PORT_LDR=1.
- One sub-module, mem_arb_pick: combinational 2-way picker.
  - Inputs: req[1:0], last_grant, FIXED_PRIO.
  - Outputs: valid, winner.
- FSM, latches and rdata registers live in the top.

## Test plan
1. Reset: hold rst=0 with both req=1 -> all outputs 0, busy=0. Release -> port 0 granted first.
2. Port 0 write:
   - stimulus: addr 0x8000, data 0xA5;
   - one cycle later: mem_ce=mem_w=1, mem_addr=0x8000, mem_wdata=0xA5 for exactly one cycle;
   - m0_ack pulses in cycle 2;
   - m0_rdata and m1_rdata unchanged.
3. Port 1 read:
   - stimulus: addr 0x0010, memory model returns 0x3C one cycle after ce+r;
   - required strobe sequence: RD, then RD_OE;
   - m1_ack in cycle 3 with m1_rdata=0x3C; m0_rdata unchanged.
4. Both ports requesting reads continuously, FIXED_PRIO=0 -> grants alternate 0,1,0,1, each ack 4 cycles apart. With FIXED_PRIO=1 -> port 0 served every time, m1_ack never pulses until m0_req drops.
5. Reset asserted during RD_OE -> strobes drop immediately, no ack. After release the same held request completes normally.
6. Port 0 holds req through ack with changed fields (write 0x0001 = 0x11, then read 0x0001) -> read returns 0x11, with one IDLE cycle between ack and the next WR/RD.
